cnn_layer_par: RTL and testbench

Parametrised parallel convolution-layer engine. It is the successor to the fixed four-thread `CNN_LayerHDL`, generalised in channel count, outputs per channel, tap count and word width, with a streaming input handshake, a channel-enable mask and an optional ReLU. Each accepted input beat feeds one signed sample per channel, and every enabled channel accumulates `NUM_W` dot products over `K_LEN` taps. On completion, per-channel outputs are rounded, saturated and held, and per-channel `finished` flags are raised.

---
 rtl/cnn_pkg.sv | 42 ++++
 rtl/cnn_layer_par_if.sv | 26 ++
 rtl/cnn_mac_lane.sv | 63 ++++++
 rtl/cnn_layer_par.sv | 142 ++++++++++++++
 tb/tb_cnn_layer_par.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// Shared types and helpers for the parallel convolution-layer engine.
// Holds the FSM encoding, default sizes and the rounding/saturation helper.
package cnn_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_FRAC   = 8;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_NUM_W  = 2;
  localparam int DEF_K_LEN  = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_SCALE = 2'd2,
    ST_DONE  = 2'd3
  } cnn_state_e;

  // Round half up by FRAC bits, then clamp to a signed data_w range.
  // Accumulators up to 63 bits are carried in a 64-bit working value.
  function automatic logic signed [63:0] sat_round(
    input logic signed [63:0] acc,
    input int                 frac,
    input int                 data_w
  );
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r = acc;
    if (frac > 0) begin
      r = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    end
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/cnn_layer_par_if.sv
// Streaming input port of the convolution engine.
// One beat carries a sample for every channel.
interface cnn_layer_par_if
  import cnn_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_CH*DATA_W-1:0] in_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/cnn_mac_lane.sv
// One (channel, weight-set) lane: accumulator, MAC and output stage.
// The output word is held until the next clear or reset.
module cnn_mac_lane
  import cnn_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC   = DEF_FRAC,
  parameter int ACC_W  = 2*DEF_DATA_W+4+1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              mac_en,
  input  logic              scale_en,
  input  logic              relu,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] weight,
  output logic [DATA_W-1:0] out
);

  logic signed [ACC_W-1:0]    acc_q;
  logic signed [ACC_W-1:0]    acc_d;
  logic [DATA_W-1:0]          out_q;
  logic [DATA_W-1:0]          out_d;
  logic signed [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]          res;

  // Next accumulator and output word.
  always_comb begin
    prod = $signed(sample) * $signed(weight);
    res  = DATA_W'(sat_round(64'(acc_q), FRAC, DATA_W));
    if (relu && res[DATA_W-1]) begin
      res = '0;
    end
    acc_d = acc_q;
    out_d = out_q;
    if (clear) begin
      acc_d = '0;
      out_d = '0;
    end else begin
      if (mac_en) begin
        acc_d = acc_q + ACC_W'(prod);
      end
      if (scale_en) begin
        out_d = res;
      end
    end
  end

  // Lane state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      out_q <= '0;
    end else begin
      acc_q <= acc_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/cnn_layer_par.sv
// Parallel convolution layer: FSM, weight store, tap counter.
// Lanes are replicated per channel and per weight set.
module cnn_layer_par
  import cnn_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC   = DEF_FRAC,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int NUM_W  = DEF_NUM_W,
  parameter int K_LEN  = DEF_K_LEN,
  parameter int ACC_W  = 2*DATA_W+$clog2(K_LEN)+1,
  localparam int CH_IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int W_IW  = (NUM_W > 1) ? $clog2(NUM_W) : 1,
  localparam int TAP_W = (K_LEN > 1) ? $clog2(K_LEN) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [NUM_CH-1:0]              ch_en,
  input  logic                           relu_en,
  input  logic                           wt_we,
  input  logic [CH_IW-1:0]               wt_ch,
  input  logic [W_IW-1:0]                wt_w,
  input  logic [TAP_W-1:0]               wt_tap,
  input  logic [DATA_W-1:0]              wt_data,
  cnn_layer_par_if.slave                 in_if,
  output logic [NUM_CH*NUM_W*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]              finished
);

  cnn_state_e        state_q, state_d;
  logic [TAP_W-1:0]  tap_q, tap_d;
  logic [NUM_CH-1:0] ch_en_q, ch_en_d;
  logic [NUM_CH-1:0] fin_q, fin_d;
  logic              relu_q, relu_d;
  logic              rdy_q, rdy_d;
  logic [DATA_W-1:0] wt_q [NUM_CH][NUM_W][K_LEN];
  logic [DATA_W-1:0] wt_d [NUM_CH][NUM_W][K_LEN];
  logic              idle_like, go, hs, last, wt_ok;

  // Pass sequencing: start, tap counting, scale and done.
  always_comb begin
    idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
    go        = idle_like && start;
    hs        = (state_q == ST_RUN) && rdy_q && in_if.in_valid;
    last      = (tap_q == TAP_W'(K_LEN - 1));
    state_d   = state_q;
    tap_d     = tap_q;
    ch_en_d   = ch_en_q;
    relu_d    = relu_q;
    fin_d     = fin_q;
    unique case (1'b1)
      idle_like: begin
        if (start) begin
          state_d = ST_RUN;
          tap_d   = '0;
          ch_en_d = ch_en;
          relu_d  = relu_en;
          fin_d   = '0;
        end
      end
      state_q == ST_RUN: begin
        fin_d = fin_q | ~ch_en_q;
        if (hs) begin
          tap_d = last ? '0 : tap_q + TAP_W'(1);
          if (last) begin
            state_d = ST_SCALE;
          end
        end
      end
      state_q == ST_SCALE: begin
        fin_d   = '1;
        state_d = ST_DONE;
      end
      default: ;
    endcase
    rdy_d = (state_d == ST_RUN);
  end

  // Weight store updates, only outside an active pass.
  always_comb begin
    wt_d  = wt_q;
    wt_ok = wt_we && idle_like
         && (32'(wt_ch) < NUM_CH)
         && (32'(wt_w) < NUM_W)
         && (32'(wt_tap) < K_LEN);
    if (wt_ok) begin
      wt_d[wt_ch][wt_w][wt_tap] = wt_data;
    end
  end

  // Control and weight registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tap_q   <= '0;
      ch_en_q <= '0;
      relu_q  <= 1'b0;
      fin_q   <= '0;
      rdy_q   <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        for (int w = 0; w < NUM_W; w++) begin
          for (int t = 0; t < K_LEN; t++) begin
            wt_q[c][w][t] <= '0;
          end
        end
      end
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      ch_en_q <= ch_en_d;
      relu_q  <= relu_d;
      fin_q   <= fin_d;
      rdy_q   <= rdy_d;
      wt_q    <= wt_d;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    for (genvar w = 0; w < NUM_W; w++) begin : g_w
      cnn_mac_lane #(
        .DATA_W (DATA_W),
        .FRAC   (FRAC),
        .ACC_W  (ACC_W)
      ) u_lane (
        .clk      (clk),
        .reset    (reset),
        .clear    (go),
        .mac_en   (hs && ch_en_q[c]),
        .scale_en ((state_q == ST_SCALE) && ch_en_q[c]),
        .relu     (relu_q),
        .sample   (in_if.in_data[c*DATA_W +: DATA_W]),
        .weight   (wt_q[c][w][tap_q]),
        .out      (out_data[(c*NUM_W+w)*DATA_W +: DATA_W])
      );
    end
  end

  assign in_if.in_ready = rdy_q;
  assign finished       = fin_q;

endmodule

// File: tb/tb_cnn_layer_par.sv
// Directed bench for cnn_layer_par with a result scoreboard.
// Expected words come from a behavioural dot-product model.
module tb_cnn_layer_par;

  localparam int NCH = 4;
  localparam int NW  = 2;
  localparam int K   = 9;
  localparam int DW  = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [3:0]     ch_en;
  logic           relu_en;
  logic           wt_we;
  logic [1:0]     wt_ch;
  logic [0:0]     wt_w;
  logic [3:0]     wt_tap;
  logic [15:0]    wt_data;
  logic [127:0]   out_data;
  logic [3:0]     finished;

  int checks = 0;
  int errors = 0;

  logic [127:0]       exp_q[$];
  logic signed [15:0] wm [NCH][NW][K];
  logic signed [15:0] in_mem [K][NCH];
  logic [3:0]         en_m;
  logic               relu_m;
  logic [127:0]       all_900;

  cnn_layer_par_if #(.NUM_CH(NCH), .DATA_W(DW)) in_if ();

  cnn_layer_par dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .ch_en    (ch_en),
    .relu_en  (relu_en),
    .wt_we    (wt_we),
    .wt_ch    (wt_ch),
    .wt_w     (wt_w),
    .wt_tap   (wt_tap),
    .wt_data  (wt_data),
    .in_if    (in_if),
    .out_data (out_data),
    .finished (finished)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model();
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < NCH; c++) begin
      for (int w = 0; w < NW; w++) begin
        longint acc;
        longint v;
        acc = 0;
        if (en_m[c]) begin
          for (int k = 0; k < K; k++) begin
            acc += longint'(in_mem[k][c]) * longint'(wm[c][w][k]);
          end
          v = (acc + 128) >>> 8;
          if (v > 32767) v = 32767;
          if (v < -32768) v = -32768;
          if (relu_m && v < 0) v = 0;
          r[(c*NW+w)*DW +: DW] = v[15:0];
        end
      end
    end
    return r;
  endfunction

  task automatic clear_wm();
    for (int c = 0; c < NCH; c++)
      for (int w = 0; w < NW; w++)
        for (int t = 0; t < K; t++)
          wm[c][w][t] = '0;
  endtask

  task automatic write_w(input int c, input int w, input int t,
                         input logic [15:0] d, input bit take);
    wt_we   = 1'b1;
    wt_ch   = c[1:0];
    wt_w    = w[0:0];
    wt_tap  = t[3:0];
    wt_data = d;
    tick();
    wt_we   = 1'b0;
    if (take) wm[c][w][t] = d;
  endtask

  task automatic load_all(input logic [15:0] d, input bit rnd);
    for (int c = 0; c < NCH; c++)
      for (int w = 0; w < NW; w++)
        for (int t = 0; t < K; t++)
          write_w(c, w, t, rnd ? 16'($urandom) : d, 1'b1);
  endtask

  task automatic fill(input logic [15:0] d, input bit rnd);
    for (int k = 0; k < K; k++)
      for (int c = 0; c < NCH; c++)
        in_mem[k][c] = rnd ? 16'($urandom) : d;
  endtask

  task automatic start_pass(input logic [3:0] en, input logic relu);
    ch_en   = en;
    relu_en = relu;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    en_m    = en;
    relu_m  = relu;
  endtask

  task automatic feed(input int nbeats, input bit gaps, input bit poke,
                      input bit push);
    int n;
    for (int k = 0; k < nbeats; k++) begin
      if (gaps) begin
        int g;
        g = (k % 2 == 1) ? $urandom_range(1, 2) : $urandom_range(0, 1);
        for (int j = 0; j < g; j++) begin
          in_if.in_valid = 1'b0;
          ch_en   = ~en_m;
          relu_en = ~relu_m;
          start   = (j == 0);
          tick();
          start   = 1'b0;
          ch_en   = en_m;
          relu_en = relu_m;
        end
      end
      if (poke && k == 3) begin
        in_if.in_valid = 1'b0;
        write_w(0, 0, 0, 16'h7FFF, 1'b0);
      end
      in_if.in_valid = 1'b1;
      for (int c = 0; c < NCH; c++)
        in_if.in_data[c*DW +: DW] = in_mem[k][c];
      n = 0;
      while (in_if.in_ready !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      chk("in_ready wait", 128'(n < 20), 128'(1));
      tick();
    end
    in_if.in_valid = 1'b0;
    if (push) exp_q.push_back(model());
  endtask

  task automatic collect(input string tag, input bit check_lat);
    int n;
    logic [127:0] e;
    n = 0;
    while (finished !== 4'hF && n < 40) begin
      tick();
      n++;
    end
    chk({tag, " finished"}, 128'(finished), 128'(4'hF));
    if (check_lat) chk({tag, " latency"}, 128'(n), 128'(1));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    chk({tag, " out_data"}, out_data, e);
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b1;
    ch_en   = 4'hF;
    relu_en = 1'b0;
    wt_we   = 1'b0;
    wt_ch   = '0;
    wt_w    = '0;
    wt_tap  = '0;
    wt_data = '0;
    en_m    = '0;
    relu_m  = 1'b0;
    all_900 = {8{16'h0900}};
    in_if.in_valid = 1'b0;
    in_if.in_data  = '0;
    clear_wm();
    fill(16'h0000, 1'b0);

    tick();
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk("rst in_ready", 128'(in_if.in_ready), 128'(0));
    chk("rst finished", 128'(finished), 128'(0));
    chk("rst out_data", out_data, 128'(0));
    tick();
    chk("rst start ignored", 128'(in_if.in_ready), 128'(0));

    load_all(16'h0100, 1'b0);
    fill(16'h0100, 1'b0);
    start_pass(4'hF, 1'b0);
    chk("run in_ready", 128'(in_if.in_ready), 128'(1));
    feed(K, 1'b0, 1'b0, 1'b1);
    chk("scale in_ready", 128'(in_if.in_ready), 128'(0));
    chk("scale finished", 128'(finished), 128'(0));
    collect("unit", 1'b1);
    chk("unit words", out_data, all_900);

    load_all(16'h7FFF, 1'b0);
    fill(16'h7FFF, 1'b0);
    start_pass(4'hF, 1'b0);
    feed(K, 1'b0, 1'b0, 1'b1);
    collect("sat pos", 1'b1);
    chk("sat pos word", 128'(out_data[15:0]), 128'(16'h7FFF));

    fill(16'h8000, 1'b0);
    start_pass(4'hF, 1'b0);
    feed(K, 1'b0, 1'b0, 1'b1);
    collect("sat neg", 1'b1);
    chk("sat neg word", 128'(out_data[127:112]), 128'(16'h8000));

    start_pass(4'hF, 1'b1);
    feed(K, 1'b0, 1'b0, 1'b1);
    collect("relu", 1'b1);
    chk("relu words", out_data, 128'(0));

    load_all(16'h0100, 1'b0);
    fill(16'h0100, 1'b0);
    start_pass(4'hF, 1'b0);
    feed(K, 1'b1, 1'b0, 1'b1);
    collect("backpressure", 1'b0);
    chk("bp words", out_data, all_900);
    tick();
    tick();
    chk("done in_ready", 128'(in_if.in_ready), 128'(0));
    chk("done hold", out_data, all_900);

    start_pass(4'b0101, 1'b0);
    chk("mask E0 fin", 128'(finished), 128'(0));
    chk("mask E0 out", out_data, 128'(0));
    tick();
    chk("mask E0+1 fin", 128'(finished), 128'(4'b1010));
    feed(K, 1'b0, 1'b0, 1'b1);
    collect("mask", 1'b1);

    load_all(16'h0000, 1'b1);
    fill(16'h0000, 1'b1);
    start_pass(4'b1011, 1'b0);
    feed(K, 1'b1, 1'b0, 1'b1);
    collect("random", 1'b0);
    fill(16'h0000, 1'b1);
    start_pass(4'hF, 1'b1);
    feed(K, 1'b0, 1'b0, 1'b1);
    collect("random relu", 1'b1);

    load_all(16'h0100, 1'b0);
    fill(16'h0100, 1'b0);
    start_pass(4'hF, 1'b0);
    feed(5, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_wm();
    chk("abort in_ready", 128'(in_if.in_ready), 128'(0));
    chk("abort finished", 128'(finished), 128'(0));
    chk("abort out_data", out_data, 128'(0));
    start_pass(4'hF, 1'b0);
    feed(K, 1'b0, 1'b0, 1'b1);
    collect("post reset", 1'b1);
    chk("post reset words", out_data, 128'(0));

    load_all(16'h0100, 1'b0);
    start_pass(4'hF, 1'b0);
    feed(K, 1'b1, 1'b1, 1'b1);
    collect("wt in run", 1'b0);
    chk("wt in run words", out_data, all_900);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
